uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_tx_arb.sv | 123 ++++++++++++
 tb/tb_uart_tx_arb.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - two-requester round-robin arbiter in front of a shared UART transmitter
// Optional watchdog on the tx_busy handshake: define UART_ARB_TIMEOUT_EN.
module uart_tx_arb #(
    parameter int CLK_FREQ = 50000000,
    parameter int UART_BPS = 115200
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       req0,
    input  logic [7:0] data0,
    output logic       gnt0,
    input  logic       req1,
    input  logic [7:0] data1,
    output logic       gnt1,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_busy,
    output logic       arb_busy,
`ifdef UART_ARB_TIMEOUT_EN
    output logic       err_timeout,
`endif
    output logic       last_gnt
);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t state;
    logic   win;

    // Under contention the requester that did not win last time goes next.
    assign win      = (req0 & req1) ? ~last_gnt : req1;
    assign arb_busy = (state != IDLE);

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TO_CYCLES = 12 * CLK_FREQ / UART_BPS;
    localparam int TO_W      = $clog2(TO_CYCLES + 1);

    logic [TO_W-1:0] to_cnt;
    logic            to_expired;

    assign to_expired = (to_cnt == TO_W'(TO_CYCLES - 1));
`endif

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state    <= IDLE;
            tx_start <= 1'b0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            tx_data  <= 8'h00;
            last_gnt <= 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
            to_cnt      <= '0;
            err_timeout <= 1'b0;
`endif
        end else begin
            tx_start <= 1'b0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            to_cnt <= (state == WAIT_BUSY || state == WAIT_DONE) ? to_cnt + 1'b1 : '0;
`endif
            case (state)
                IDLE: begin
                    // Pulses are registered here so they appear during the LAUNCH cycle.
                    if (req0 | req1) begin
                        state    <= LAUNCH;
                        tx_start <= 1'b1;
                        gnt0     <= ~win;
                        gnt1     <= win;
                        tx_data  <= win ? data1 : data0;
                        last_gnt <= win;
                    end
                end
                LAUNCH: begin
                    state <= WAIT_BUSY;
`ifdef UART_ARB_TIMEOUT_EN
                    to_cnt <= '0;
`endif
                end
                WAIT_BUSY: begin
`ifdef UART_ARB_TIMEOUT_EN
                    if (to_expired) begin
                        state       <= IDLE;
                        err_timeout <= 1'b1;
                        to_cnt      <= '0;
                    end else if (tx_busy) begin
                        state  <= WAIT_DONE;
                        to_cnt <= '0;
                    end
`else
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end
`endif
                end
                WAIT_DONE: begin
`ifdef UART_ARB_TIMEOUT_EN
                    if (to_expired) begin
                        state       <= IDLE;
                        err_timeout <= 1'b1;
                        to_cnt      <= '0;
                    end else if (!tx_busy) begin
                        state  <= IDLE;
                        to_cnt <= '0;
                    end
`else
                    if (!tx_busy) begin
                        state <= IDLE;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb/tb_uart_tx_arb.sv - directed and randomized checks of uart_tx_arb against a transaction-level model
module tb_uart_tx_arb;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic [7:0] data0 = 8'h00;
    logic [7:0] data1 = 8'h00;
    logic       tx_busy = 1'b0;
    logic       gnt0, gnt1, tx_start, arb_busy, last_gnt;
    logic [7:0] tx_data;

    uart_tx_arb dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .req0     (req0),
        .data0    (data0),
        .gnt0     (gnt0),
        .req1     (req1),
        .data1    (data1),
        .gnt1     (gnt1),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .arb_busy (arb_busy),
        .last_gnt (last_gnt)
    );

    always #5 sys_clk = ~sys_clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: a byte is in flight from its launch until the transmitter has
    // shown busy and then idle again; only with nothing in flight may a new
    // byte be granted.
    bit         m_inflight = 1'b0;
    bit         m_fresh = 1'b0;
    bit         m_rose = 1'b0;
    bit         m_last = 1'b1;
    bit [1:0]   m_gnt = 2'b00;
    logic [7:0] m_data = 8'h00;

    bit auto_tx = 1'b0;
    int tx_wait = 0;
    int tx_len = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        bit w;
        m_gnt = 2'b00;
        if (sys_rst) begin
            m_inflight = 1'b0;
            m_fresh    = 1'b0;
            m_rose     = 1'b0;
            m_last     = 1'b1;
            m_data     = 8'h00;
        end else if (m_fresh) begin
            m_fresh = 1'b0;
        end else if (m_inflight) begin
            if (!m_rose) m_rose = tx_busy;
            else if (!tx_busy) m_inflight = 1'b0;
        end else if (req0 || req1) begin
            w          = (req0 && req1) ? !m_last : req1;
            m_last     = w;
            m_data     = w ? data1 : data0;
            m_fresh    = 1'b1;
            m_inflight = 1'b1;
            m_rose     = 1'b0;
            m_gnt      = w ? 2'b10 : 2'b01;
        end
    endtask

    task automatic drive_tx();
        if (m_fresh) begin
            tx_wait = $urandom_range(0, 3);
            tx_len  = $urandom_range(1, 12);
            tx_busy = 1'b0;
        end else if (tx_wait > 0) begin
            tx_wait--;
            tx_busy = 1'b0;
        end else if (tx_len > 0) begin
            tx_busy = 1'b1;
            tx_len--;
        end else begin
            tx_busy = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        model_update();
        @(negedge sys_clk);
        chk("tx_start", tx_start, m_fresh);
        chk("gnt0", gnt0, m_gnt[0]);
        chk("gnt1", gnt1, m_gnt[1]);
        chk("tx_data", tx_data, m_data);
        chk("arb_busy", arb_busy, m_inflight);
        chk("last_gnt", last_gnt, m_last);
        if (auto_tx) drive_tx();
    endtask

    task automatic drive_req();
        if (m_gnt[0]) begin
            data0 = 8'($urandom);
            req0  = ($urandom_range(0, 3) != 0);
        end else if (!req0) begin
            if ($urandom_range(0, 2) == 0) begin
                req0  = 1'b1;
                data0 = 8'($urandom);
            end
        end else if ($urandom_range(0, 39) == 0) begin
            req0 = 1'b0;
        end
        if (m_gnt[1]) begin
            data1 = 8'($urandom);
            req1  = ($urandom_range(0, 3) != 0);
        end else if (!req1) begin
            if ($urandom_range(0, 2) == 0) begin
                req1  = 1'b1;
                data1 = 8'($urandom);
            end
        end else if ($urandom_range(0, 39) == 0) begin
            req1 = 1'b0;
        end
    endtask

    initial begin
        int got[$];
        int exp_order[4];
        int ns;
        int ng;

        // Reset state
        sys_rst = 1'b1;
        step();
        step();
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_last_gnt", last_gnt, 1'b1);
        chk("rst_arb_busy", arb_busy, 1'b0);
        sys_rst = 1'b0;

        // Single request
        req0  = 1'b1;
        data0 = 8'hA5;
        step();
        chk("single_start", tx_start, 1'b1);
        chk("single_gnt0", gnt0, 1'b1);
        chk("single_data", tx_data, 8'hA5);
        req0 = 1'b0;
        step();
        tx_busy = 1'b1;
        repeat (10) step();
        chk("single_still_busy", arb_busy, 1'b1);
        tx_busy = 1'b0;
        step();
        chk("single_idle", arb_busy, 1'b0);

        // Contention straight after reset
        sys_rst = 1'b1;
        step();
        sys_rst = 1'b0;
        req0  = 1'b1;
        req1  = 1'b1;
        data0 = 8'h11;
        data1 = 8'h22;
        auto_tx = 1'b1;
        for (int i = 0; i < 200 && got.size() < 4; i++) begin
            step();
            if (tx_start === 1'b1) got.push_back(int'(tx_data));
        end
        chk("rr_count", got.size(), 4);
        exp_order = '{8'h11, 8'h22, 8'h11, 8'h22};
        for (int i = 0; i < got.size() && i < 4; i++) chk("rr_order", got[i], exp_order[i]);
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (40) step();
        auto_tx = 1'b0;
        tx_busy = 1'b0;
        step();
        chk("rr_idle", arb_busy, 1'b0);

        // Back-pressure with a second byte pending
        req0  = 1'b1;
        data0 = 8'h3C;
        step();
        chk("bp_first_data", tx_data, 8'h3C);
        data0 = 8'h3D;
        step();
        tx_busy = 1'b1;
        ns = 0;
        repeat (100) begin
            step();
            if (tx_start === 1'b1) ns++;
        end
        chk("bp_no_start", ns, 0);
        tx_busy = 1'b0;
        step();
        chk("bp_idle_cycle", tx_start, 1'b0);
        step();
        chk("bp_launch", tx_start, 1'b1);
        chk("bp_data", tx_data, 8'h3D);
        req0 = 1'b0;

        // Reset in WAIT_DONE
        step();
        tx_busy = 1'b1;
        step();
        chk("mid_busy", arb_busy, 1'b1);
        sys_rst = 1'b1;
        step();
        chk("mid_rst_busy", arb_busy, 1'b0);
        chk("mid_rst_data", tx_data, 8'h00);
        chk("mid_rst_start", tx_start, 1'b0);
        chk("mid_rst_gnt0", gnt0, 1'b0);
        sys_rst = 1'b0;
        tx_busy = 1'b0;
        step();

        // Dropped request while a byte is in flight
        req0  = 1'b1;
        data0 = 8'h77;
        step();
        req0 = 1'b0;
        step();
        req1  = 1'b1;
        data1 = 8'h5C;
        ns = 0;
        ng = 0;
        step();
        req1 = 1'b0;
        tx_busy = 1'b1;
        repeat (3) begin
            step();
            if (tx_start === 1'b1) ns++;
            if (gnt1 === 1'b1) ng++;
        end
        tx_busy = 1'b0;
        repeat (4) begin
            step();
            if (tx_start === 1'b1) ns++;
            if (gnt1 === 1'b1) ng++;
        end
        chk("drop_gnt1", ng, 0);
        chk("drop_start", ns, 0);
        chk("drop_idle", arb_busy, 1'b0);

        // Randomized traffic
        auto_tx = 1'b1;
        repeat (4000) begin
            sys_rst = ($urandom_range(0, 299) == 0);
            step();
            drive_req();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
